// File: rtl/period_readout_serializer_pkg.sv
// Shared types and width helpers for the period readout path.
package period_readout_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  function automatic int word_bits(input int counter_bits);
    return counter_bits + 1;
  endfunction

  function automatic int total_bits(input int channels, input int counter_bits);
    return channels * (counter_bits + 1);
  endfunction

endpackage

// File: rtl/period_readout_serializer_capture_bank.sv
// Per-channel period capture registers with valid flags; a new pulse wins over the frame-load clear.
module period_capture_bank #(
  parameter int CHANNELS     = 8,
  parameter int COUNTER_BITS = 15
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [CHANNELS*COUNTER_BITS-1:0] period_i,
  input  logic [CHANNELS-1:0]              pulse_i,
  input  logic                             clr_i,
  output logic [CHANNELS*COUNTER_BITS-1:0] cap_o,
  output logic [CHANNELS-1:0]              vld_o
);

  logic [CHANNELS*COUNTER_BITS-1:0] cap_q, cap_d;
  logic [CHANNELS-1:0]              vld_q, vld_d;

  always_comb begin
    cap_d = cap_q;
    vld_d = clr_i ? '0 : vld_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (pulse_i[i]) begin
        cap_d[i*COUNTER_BITS +: COUNTER_BITS] = period_i[i*COUNTER_BITS +: COUNTER_BITS];
        vld_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cap_q <= '0;
      vld_q <= '0;
    end else begin
      cap_q <= cap_d;
      vld_q <= vld_d;
    end
  end

  assign cap_o = cap_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/period_readout_serializer.sv
// Captures per-channel periods and serializes {valid, period} words, channel 0 first, MSB first.
module period_readout_serializer
  import period_readout_serializer_pkg::*;
#(
  parameter int CHANNELS     = 8,
  parameter int COUNTER_BITS = 15
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [CHANNELS*COUNTER_BITS-1:0] PERIOD_IN,
  input  logic [CHANNELS-1:0]              PULSE_IN,
  input  logic                             START,
  input  logic                             SHIFT_EN,
  output logic                             SOUT,
  output logic                             SVALID,
  output logic                             SFRAME,
  output logic                             BUSY,
  output logic                             DONE
);

  localparam int WORD_BITS  = word_bits(COUNTER_BITS);
  localparam int TOTAL_BITS = total_bits(CHANNELS, COUNTER_BITS);
  localparam int CNT_W      = $clog2(TOTAL_BITS + 1);

  state_e                           state_q, state_d;
  logic [TOTAL_BITS-1:0]            sbuf_q, sbuf_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [TOTAL_BITS-1:0]            load_word;
  logic [CHANNELS*COUNTER_BITS-1:0] cap;
  logic [CHANNELS-1:0]              vld;

  period_capture_bank #(
    .CHANNELS    (CHANNELS),
    .COUNTER_BITS(COUNTER_BITS)
  ) u_bank (
    .clk_i   (CLK),
    .rst_i   (RST),
    .period_i(PERIOD_IN),
    .pulse_i (PULSE_IN),
    .clr_i   (state_q == ST_LOAD),
    .cap_o   (cap),
    .vld_o   (vld)
  );

  // Channel 0 occupies the top word so it leaves the buffer first.
  always_comb begin
    load_word = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      load_word[TOTAL_BITS-1-i*WORD_BITS -: WORD_BITS] = {vld[i], cap[i*COUNTER_BITS +: COUNTER_BITS]};
    end
  end

  always_comb begin
    state_d = state_q;
    sbuf_d  = sbuf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (START) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        sbuf_d  = load_word;
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (SHIFT_EN) begin
          sbuf_d = sbuf_q << 1;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(TOTAL_BITS - 1)) state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      sbuf_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sbuf_q  <= sbuf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign SVALID = (state_q == ST_SHIFT);
  assign SOUT   = SVALID & sbuf_q[TOTAL_BITS-1];
  assign SFRAME = SVALID && ((cnt_q % CNT_W'(WORD_BITS)) == '0);
  assign BUSY   = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
  assign DONE   = (state_q == ST_FIN);

endmodule

// File: tb/tb_period_readout_serializer.sv
// Scoreboard bench: driver keeps a frame-level reference model, monitor decodes the serial stream.
module tb_period_readout_serializer;

  localparam int CH = 4;
  localparam int CB = 15;
  localparam int WB = CB + 1;
  localparam int TB = CH * WB;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [CH*CB-1:0] PERIOD_IN = '0;
  logic [CH-1:0] PULSE_IN = '0;
  logic          START = 1'b0;
  logic          SHIFT_EN = 1'b1;
  logic          SOUT, SVALID, SFRAME, BUSY, DONE;

  period_readout_serializer #(
    .CHANNELS    (CH),
    .COUNTER_BITS(CB)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .PERIOD_IN(PERIOD_IN),
    .PULSE_IN (PULSE_IN),
    .START    (START),
    .SHIFT_EN (SHIFT_EN),
    .SOUT     (SOUT),
    .SVALID   (SVALID),
    .SFRAME   (SFRAME),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 load, 2 shifting, 3 finished.
  int            m_phase = 0;
  int            m_bits  = 0;
  logic [CB-1:0] m_cap[CH];
  logic          m_vld[CH];
  logic [WB-1:0] exp_q[$];
  int            done_seen = 0;

  task automatic cyc();
    @(posedge CLK);
    if (RST) begin
      m_phase = 0;
      m_bits  = 0;
      for (int i = 0; i < CH; i++) begin m_cap[i] = '0; m_vld[i] = 1'b0; end
      exp_q.delete();
    end else begin
      case (m_phase)
        0: if (START) m_phase = 1;
        1: begin
          for (int i = 0; i < CH; i++) exp_q.push_back({m_vld[i], m_cap[i]});
          for (int i = 0; i < CH; i++) m_vld[i] = 1'b0;
          m_bits  = 0;
          m_phase = 2;
        end
        2: if (SHIFT_EN) begin
          m_bits++;
          if (m_bits == TB) m_phase = 3;
        end
        default: m_phase = 0;
      endcase
      for (int i = 0; i < CH; i++) begin
        if (PULSE_IN[i]) begin
          m_cap[i] = PERIOD_IN[i*CB +: CB];
          m_vld[i] = 1'b1;
        end
      end
    end
    #1;
    START    = 1'b0;
    PULSE_IN = '0;
  endtask

  task automatic set_ch(input int ch, input logic [CB-1:0] val);
    PERIOD_IN[ch*CB +: CB] = val;
    PULSE_IN[ch] = 1'b1;
  endtask

  // pat 0: SHIFT_EN high; pat 1: 1,0,0,1 repeating; pat 2: random.
  task automatic run_frame(input int pat, input bit hold_start, input int load_ch,
                           input logic [CB-1:0] load_val, output int lat);
    int k;
    bit got;
    k    = 0;
    got  = 0;
    lat  = 0;
    SHIFT_EN = 1'b1;
    START = 1'b1;
    cyc();
    lat = 1;
    for (int n = 0; n < 1000 && !got; n++) begin
      if (n == 0 && load_ch >= 0) set_ch(load_ch, load_val);
      case (pat)
        0:       SHIFT_EN = 1'b1;
        1:       SHIFT_EN = ((k % 4) == 0) || ((k % 4) == 3);
        default: SHIFT_EN = ($urandom_range(0, 3) != 0);
      endcase
      k++;
      START = hold_start;
      cyc();
      lat++;
      if (DONE) got = 1;
    end
    if (!got) check("done_timeout", 0, 1);
    START = hold_start;
    SHIFT_EN = 1'b1;
    cyc();
  endtask

  int   mbit = 0;
  logic [WB-1:0] acc = '0;
  logic [WB-1:0] w;
  bit   prev_stall = 0, prev_sout = 0, prev_sframe = 0, prev_rst = 0;

  always @(negedge CLK) begin
    if (prev_rst && !RST) begin
      check("rst_sout", SOUT, 0);
      check("rst_sframe", SFRAME, 0);
    end
    check("svalid", SVALID, m_phase == 2);
    check("busy", BUSY, (m_phase == 1) || (m_phase == 2));
    check("done", DONE, m_phase == 3);
    if (RST) begin
      mbit = 0;
      acc  = '0;
      prev_stall = 0;
    end else begin
      if (DONE) begin
        done_seen++;
        check("frame_bits", mbit, TB);
        mbit = 0;
      end
      if (SVALID) begin
        if (prev_stall) begin
          check("stall_sout", SOUT, prev_sout);
          check("stall_sframe", SFRAME, prev_sframe);
        end
        check("sframe", SFRAME, (mbit % WB) == 0);
        if (SHIFT_EN) begin
          acc = {acc[WB-2:0], SOUT};
          mbit++;
          if ((mbit % WB) == 0) begin
            if (exp_q.size() == 0) check("word_unexpected", acc, 32'hFFFF_FFFF);
            else begin
              w = exp_q.pop_front();
              check("word", acc, w);
            end
          end
        end
        prev_stall  = !SHIFT_EN;
        prev_sout   = SOUT;
        prev_sframe = SFRAME;
      end else begin
        prev_stall = 0;
      end
    end
    prev_rst = RST;
  end

  int lat, d0, guard;

  initial begin
    for (int i = 0; i < CH; i++) begin m_cap[i] = '0; m_vld[i] = 1'b0; end
    RST = 1'b1;
    cyc();
    cyc();
    RST = 1'b0;
    cyc();

    // Single frame, full throughput
    set_ch(0, 15'h0001); set_ch(1, 15'h1234); set_ch(2, 15'h7FFF); set_ch(3, 15'h0000);
    cyc();
    d0 = done_seen;
    run_frame(0, 0, -1, '0, lat);
    check("done_latency", lat, TB + 2);
    check("done_count_s1", done_seen - d0, 1);

    // Stale channels
    set_ch(2, 15'h00AA);
    cyc();
    run_frame(0, 0, -1, '0, lat);
    run_frame(0, 0, -1, '0, lat);

    // Backpressure
    set_ch(0, 15'h0001); set_ch(1, 15'h1234); set_ch(2, 15'h7FFF); set_ch(3, 15'h0000);
    cyc();
    d0 = done_seen;
    run_frame(1, 0, -1, '0, lat);
    check("done_count_bp", done_seen - d0, 1);

    // Pulse during the load cycle lands in the next frame
    run_frame(0, 0, 1, 15'h0055, lat);
    run_frame(0, 0, -1, '0, lat);

    // START held through shift and fin
    d0 = done_seen;
    run_frame(0, 1, -1, '0, lat);
    cyc();
    check("busy_after_ignored_start", BUSY, 0);
    check("done_count_start", done_seen - d0, 1);

    // Reset in mid-frame
    set_ch(3, 15'h4321);
    cyc();
    d0 = done_seen;
    START = 1'b1;
    cyc();
    guard = 0;
    while (m_bits < 20 && guard < 200) begin cyc(); guard++; end
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    for (int i = 0; i < 70; i++) cyc();
    check("no_done_after_rst", done_seen - d0, 0);
    run_frame(0, 0, -1, '0, lat);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 7) == 0) set_ch(i, 15'($urandom));
      START    = ($urandom_range(0, 19) == 0);
      SHIFT_EN = ($urandom_range(0, 3) != 0);
      RST      = ($urandom_range(0, 799) == 0);
      cyc();
    end
    RST = 1'b0;
    SHIFT_EN = 1'b1;
    for (int i = 0; i < 80; i++) cyc();
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
